abus_onchip_bridge: RTL

Upstream master for the 4096x32 single-port on-chip RAM. Converts 16-bit halfword requests from the cartridge A-bus front end into 32-bit memory cycles, with big-endian halfword lane mapping and a one-word read buffer that serves sequential halfword reads without a second RAM access. Writes go straight through to RAM and keep the buffer coherent. Saturating hit/miss counters support firmware profiling.

---
 rtl/abus_onchip_bridge_if.sv | 29 ++
 rtl/abus_onchip_bridge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/abus_onchip_bridge_if.sv
// Host-side halfword request bus of the A-bus on-chip RAM bridge.
//   host_valid/host_ready : request handshake (accept = valid & ready)
//   host_write            : 1 = write, 0 = read
//   host_addr             : halfword address, bit0 selects the lane
//   host_be / host_wdata  : halfword byte enables ([1] = upper byte) and data
//   host_rvalid/host_rdata: one-cycle read-data return
// master = A-bus front end, slave = bridge.
interface abus_onchip_bridge_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              host_valid;
    logic              host_ready;
    logic              host_write;
    logic [ADDR_W:0]   host_addr;
    logic [1:0]        host_be;
    logic [15:0]       host_wdata;
    logic              host_rvalid;
    logic [15:0]       host_rdata;

    modport master (
        output host_valid, host_write, host_addr, host_be, host_wdata,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_write, host_addr, host_be, host_wdata,
        output host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/abus_onchip_bridge.sv
// Bridge from 16-bit A-bus halfword requests to a 4096x32 single-port RAM.
// Big-endian lane map (host_addr[0]=0 -> bits [31:16]), one-word read buffer
// serving sequential halfword reads, write-through with buffer merge, and
// saturating hit/miss counters.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   host           : halfword request bus (slave side)
//   buf_invalidate : pulse, drops the read buffer
//   mem_*          : RAM master port; readdata valid the cycle after a read
//   stat_hits      : reads served from the buffer (saturating)
//   stat_misses    : reads sent to RAM (saturating)
module abus_onchip_bridge #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    abus_onchip_bridge_if.slave host,
    input  logic                buf_invalidate,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [3:0]          mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [31:0]         mem_writedata,
    output logic                mem_clken,
    output logic                mem_reset_req,
    input  logic [31:0]         mem_readdata,
    output logic [CNT_W-1:0]    stat_hits,
    output logic [CNT_W-1:0]    stat_misses
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE_RD = 2'd1;
    localparam logic [1:0] WAIT_RD  = 2'd2;
    localparam logic [1:0] ISSUE_WR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] word_addr;
    logic              lane;
    logic              accept, rd_hit, rd_miss, wr_go;
    logic [3:0]        lane_be;
    logic [31:0]       lane_data;

    logic [ADDR_W-1:0] mem_address_d;
    logic [3:0]        mem_byteenable_d;
    logic              mem_chipselect_d, mem_write_d;
    logic [31:0]       mem_writedata_d;

    logic              buf_valid_q;
    logic [ADDR_W-1:0] buf_tag_q;
    logic [31:0]       buf_data_q;
    logic [ADDR_W-1:0] rd_word_q;
    logic              rd_lane_q;
    logic              rd_kill_q;     // invalidate seen while a miss was in flight
    logic              rvalid_q;
    logic [15:0]       rdata_q;

    assign mem_clken        = 1'b1;
    assign mem_reset_req    = reset;
    assign host.host_ready  = (state_q == IDLE);
    assign host.host_rvalid = rvalid_q;
    assign host.host_rdata  = rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Request decode, next state and next RAM command
    always_comb begin
        state_d          = state_q;
        word_addr        = host.host_addr[ADDR_W:1];
        lane             = host.host_addr[0];
        accept           = host.host_valid && (state_q == IDLE);
        rd_hit           = accept && !host.host_write && buf_valid_q &&
                           (buf_tag_q == word_addr) && !buf_invalidate;
        rd_miss          = accept && !host.host_write && !rd_hit;
        wr_go            = accept && host.host_write && (host.host_be != 2'b00);
        lane_be          = lane ? {2'b00, host.host_be} : {host.host_be, 2'b00};
        lane_data        = lane ? {16'h0000, host.host_wdata} : {host.host_wdata, 16'h0000};
        mem_address_d    = '0;
        mem_byteenable_d = 4'h0;
        mem_chipselect_d = 1'b0;
        mem_write_d      = 1'b0;
        mem_writedata_d  = 32'h0;

        case (state_q)
            IDLE: begin
                if (rd_miss)    state_d = ISSUE_RD;
                else if (wr_go) state_d = ISSUE_WR;
            end
            ISSUE_RD: state_d = WAIT_RD;
            WAIT_RD:  state_d = IDLE;
            ISSUE_WR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (rd_miss) begin
            mem_address_d    = word_addr;
            mem_byteenable_d = 4'hF;
            mem_chipselect_d = 1'b1;
        end else if (wr_go) begin
            mem_address_d    = word_addr;
            mem_byteenable_d = lane_be;
            mem_chipselect_d = 1'b1;
            mem_write_d      = 1'b1;
            mem_writedata_d  = lane_data;
        end
    end

    // RAM command registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_address    <= '0;
            mem_byteenable <= 4'h0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'h0;
        end else begin
            mem_address    <= mem_address_d;
            mem_byteenable <= mem_byteenable_d;
            mem_chipselect <= mem_chipselect_d;
            mem_write      <= mem_write_d;
            mem_writedata  <= mem_writedata_d;
        end
    end

    // Read buffer, read return and write merge
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= 32'h0;
            rd_word_q   <= '0;
            rd_lane_q   <= 1'b0;
            rd_kill_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 16'h0000;
        end else begin
            rvalid_q <= 1'b0;
            if (rd_miss) begin
                rd_word_q <= word_addr;
                rd_lane_q <= lane;
                rd_kill_q <= 1'b0;
            end
            if (buf_invalidate && (state_q == ISSUE_RD || state_q == WAIT_RD))
                rd_kill_q <= 1'b1;
            if (rd_hit) begin
                rvalid_q <= 1'b1;
                rdata_q  <= lane ? buf_data_q[15:0] : buf_data_q[31:16];
            end
            if (state_q == WAIT_RD) begin
                buf_data_q <= mem_readdata;
                buf_tag_q  <= rd_word_q;
                rvalid_q   <= 1'b1;
                rdata_q    <= rd_lane_q ? mem_readdata[15:0] : mem_readdata[31:16];
            end
            if (wr_go && buf_valid_q && (buf_tag_q == word_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_be[b]) buf_data_q[8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
            // Invalidate wins over a same-cycle fill; a killed fill stays invalid
            if (buf_invalidate)
                buf_valid_q <= 1'b0;
            else if (state_q == WAIT_RD && !rd_kill_q)
                buf_valid_q <= 1'b1;
        end
    end

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (rd_hit && (stat_hits != '1))
                stat_hits <= stat_hits + CNT_W'(1);
            if (rd_miss && (stat_misses != '1))
                stat_misses <= stat_misses + CNT_W'(1);
        end
    end
endmodule
